// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M multiply/divide unit
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = 6;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue request and regfile writeback bundle of the multiply/divide unit
interface muldiv_if;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        kill_i;
  logic        busy_o;
  logic        rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  modport master (
    output valid_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, kill_i,
    input  ready_o, busy_o, rd_wren_o, rd_addr_o, rd_data_o
  );
  modport slave (
    input  valid_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, kill_i,
    output ready_o, busy_o, rd_wren_o, rd_addr_o, rd_data_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M unit, radix-2 shift-add multiply and restoring divide on magnitudes
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic     clk_i,
  input logic     rst_i,
  muldiv_if.slave bus
);
  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [4:0]       rd_q, rd_d, rd_addr_q, rd_addr_d;
  logic [31:0]      rd_data_q, rd_data_d;
  md_op_e      op_in;
  logic        is_div, is_rem, a_neg, b_neg, accept, div0, ovf;
  logic [31:0] a_mag, b_mag, fast_res, div_res, div_fin, mul_fin, result;
  logic [32:0] mul_sum, div_diff;
  logic [63:0] mul_nxt, div_nxt, prod;
  always_comb begin
    op_in    = md_op_e'(bus.funct3_i);
    is_div   = bus.funct3_i[2];
    is_rem   = bus.funct3_i[1];
    a_neg    = (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & bus.rs1_data_i[31];
    b_neg    = (op_in inside {MD_MULH, MD_DIV, MD_REM}) & bus.rs2_data_i[31];
    a_mag    = a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
    b_mag    = b_neg ? -bus.rs2_data_i : bus.rs2_data_i;
    accept   = bus.valid_i & (state_q == IDLE) & !bus.kill_i;
    div0     = is_div & (bus.rs2_data_i == '0);
    ovf      = (op_in inside {MD_DIV, MD_REM}) & (bus.rs1_data_i == 32'h8000_0000) & (bus.rs2_data_i == '1);
    fast_res = div0 ? (is_rem ? bus.rs1_data_i : DIV_ZERO_Q) : (is_rem ? 32'h0 : 32'h8000_0000);
    // Multiplier bits leave acc[0] as the partial product shifts in from the top
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_nxt  = {mul_sum, acc_q[31:1]};
    div_diff = acc_q[63:31] - {1'b0, opb_q};
    div_nxt  = div_diff[32] ? {acc_q[62:0], 1'b0} : {div_diff[31:0], acc_q[30:0], 1'b1};
    prod     = neg_q ? -acc_q : acc_q;
    div_res  = op_q[1] ? acc_q[63:32] : acc_q[31:0];
    div_fin  = neg_q ? -div_res : div_res;
    mul_fin  = (op_q == MD_MUL) ? prod[31:0] : prod[63:32];
    result   = op_q[2] ? div_fin : mul_fin;
  end
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rd_d      = rd_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (bus.kill_i) begin
      state_d = IDLE;
    end else if (accept) begin
      op_d  = op_in;
      rd_d  = bus.rd_addr_i;
      cnt_d = '0;
      neg_d = (is_div & is_rem) ? a_neg : a_neg ^ b_neg;
      acc_d = {32'h0, is_div ? a_mag : b_mag};
      opb_d = is_div ? b_mag : a_mag;
      if (div0 | ovf) begin
        state_d   = DONE;
        rd_addr_d = bus.rd_addr_i;
        rd_data_d = fast_res;
      end else begin
        state_d = CALC;
      end
    end else if (state_q == CALC) begin
      if (cnt_q == CNT_W'(XLEN)) begin
        state_d   = DONE;
        rd_addr_d = rd_q;
        rd_data_d = result;
      end else begin
        acc_d = op_q[2] ? div_nxt : mul_nxt;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= MD_MUL;
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rd_q      <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rd_q      <= rd_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign bus.ready_o   = (state_q == IDLE);
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.rd_wren_o = (state_q == DONE) & (rd_addr_q != '0) & !bus.kill_i;
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.rd_data_o = rd_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic RV32M model
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int errors = 0;
  muldiv_if bus();
  muldiv_unit dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_md(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint sa = longint'(signed'(a));
    longint sb = longint'(signed'(b));
    longint ub = longint'({32'h0, b});
    logic [63:0] p;
    case (f3)
      3'd0: return a * b;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(logic [2:0] f3, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    bus.valid_i = 1; bus.funct3_i = f3; bus.rs1_data_i = a; bus.rs2_data_i = b; bus.rd_addr_i = rd;
    @(posedge clk); #1;
    bus.valid_i = 0; bus.rs1_data_i = $urandom; bus.rs2_data_i = $urandom; bus.rd_addr_i = 5'($urandom);
    bus.funct3_i = 3'($urandom);
  endtask

  task automatic run_op(string tag, logic [2:0] f3, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    int lat = 0;
    bit seen = 0;
    bit fast = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    check({tag, " ready"}, 64'(bus.ready_o), 1);
    issue(f3, a, b, rd);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.rd_wren_o) seen = 1;
      else begin @(posedge clk); #1; lat++; end
    end
    check({tag, " wren seen"}, 64'(seen), 1);
    check({tag, " data"}, 64'(bus.rd_data_o), 64'(ref_md(f3, a, b)));
    check({tag, " addr"}, 64'(bus.rd_addr_o), 64'(rd));
    check({tag, " latency"}, 64'(lat), fast ? 0 : 33);
    @(posedge clk); #1;
    check({tag, " pulse end"}, {63'h0, bus.rd_wren_o}, 0);
    check({tag, " idle after"}, {63'h0, bus.ready_o}, 1);
  endtask

  task automatic count_wren(int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.rd_wren_o) cnt++;
    end
  endtask

  initial begin
    int cnt, low;
    bus.valid_i = 0; bus.kill_i = 0; bus.funct3_i = 0;
    bus.rs1_data_i = 0; bus.rs2_data_i = 0; bus.rd_addr_i = 0;
    #1 rst = 1;
    #1;
    check("rst ready", 64'(bus.ready_o), 1);
    check("rst busy", 64'(bus.busy_o), 0);
    check("rst wren", 64'(bus.rd_wren_o), 0);
    check("rst addr", 64'(bus.rd_addr_o), 0);
    check("rst data", 64'(bus.rd_data_o), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    run_op("mul neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    check("mul neg value", 64'(bus.rd_data_o), 64'h0000_0000_FFFF_FFEB);
    run_op("mulhu max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd7);
    run_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    run_op("divu by0", 3'd5, 32'd9, 32'd0, 5'd10);
    run_op("remu by0", 3'd7, 32'd9, 32'd0, 5'd11);
    run_op("rem neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12);
    run_op("div neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd13);
    check("div neg value", 64'(bus.rd_data_o), 64'h0000_0000_FFFF_FFFD);

    issue(3'd0, 32'd1234, 32'd5678, 5'd14);
    repeat (5) @(posedge clk);
    #1 rst = 1;
    #1;
    check("async rst ready", 64'(bus.ready_o), 1);
    check("async rst busy", 64'(bus.busy_o), 0);
    check("async rst addr", 64'(bus.rd_addr_o), 0);
    check("async rst data", 64'(bus.rd_data_o), 0);
    @(posedge clk); #1 rst = 0;
    count_wren(40, cnt);
    check("async rst no write", 64'(cnt), 0);

    low = 0; cnt = 0;
    issue(3'd5, 32'd100, 32'd7, 5'd0);
    for (int i = 0; i < 40 && !bus.ready_o; i++) begin
      low++;
      if (bus.rd_wren_o) cnt++;
      @(posedge clk); #1;
    end
    check("x0 busy cycles", 64'(low), 34);
    check("x0 no write", 64'(cnt), 0);

    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15);
    repeat (9) @(posedge clk);
    #1 bus.kill_i = 1;
    @(posedge clk); #1 bus.kill_i = 0;
    check("kill calc ready", 64'(bus.ready_o), 1);
    count_wren(40, cnt);
    check("kill calc no write", 64'(cnt), 0);
    run_op("after kill", 3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15);

    bus.valid_i = 1; bus.kill_i = 1; bus.funct3_i = 3'd0; bus.rd_addr_i = 5'd3;
    @(posedge clk); #1;
    check("valid kill ready", 64'(bus.ready_o), 1);
    check("valid kill busy", 64'(bus.busy_o), 0);
    bus.valid_i = 0; bus.kill_i = 0;
    count_wren(40, cnt);
    check("valid kill no write", 64'(cnt), 0);

    issue(3'd5, 32'd9, 32'd0, 5'd3);
    check("done wren", 64'(bus.rd_wren_o), 1);
    bus.kill_i = 1;
    #1;
    check("done kill wren", 64'(bus.rd_wren_o), 0);
    @(posedge clk); #1 bus.kill_i = 0;
    check("done kill ready", 64'(bus.ready_o), 1);

    for (int k = 0; k < 40; k++) begin
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      run_op($sformatf("rand%0d f3=%0d", k, f3), f3, pick(), pick(), 5'($urandom_range(1, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
